// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit-side blocks: the transmit
// arbiter FSM state encoding and the default timing constants for an
// 82 ns system clock driving a 256000 baud serial line.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_DRIVE     = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } tx_arb_state_t;

    // One bit period at 82 ns / 256000 baud.
    localparam int UART_EN_HOLD        = 48;
    // Longest wait for the transmitter to report busy after a byte is offered.
    localparam int UART_PERMIT_TIMEOUT = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches the request vector starting at
// lastGrant+1 (mod NUM_REQ) and returns the first set bit.
//   reqVec      in   NUM_REQ   request bits
//   lastGrant   in   IDX_W     index granted most recently
//   grantOneHot out  NUM_REQ   one-hot winner (all zero when no request)
//   grantIdx    out  IDX_W     winner index (0 when no request)
//   grantValid  out  1         at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqVec,
    input  logic [IDX_W-1:0]   lastGrant,
    output logic [NUM_REQ-1:0] grantOneHot,
    output logic [IDX_W-1:0]   grantIdx,
    output logic               grantValid
);

    always_comb begin
        int cand;
        cand        = 0;
        grantOneHot = '0;
        grantIdx    = '0;
        grantValid  = 1'b0;
        // Offsets 1..NUM_REQ visit every requester once, the last granted one last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(lastGrant) + i) % NUM_REQ;
            if (!grantValid && reqVec[cand]) begin
                grantValid        = 1'b1;
                grantIdx          = IDX_W'(cand);
                grantOneHot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares the Uart parallel transmit port among NUM_REQ byte requesters in
// round-robin order. One byte is accepted per frame, presented on the Uart
// port with the enable held for EN_HOLD cycles, then the Permit line is
// tracked (fall = frame started, rise = frame finished).
//   Clk, Rst             clock, synchronous active-high reset
//   ReqValid/ReqData     per-requester byte offer (byte i at [8i+7:8i])
//   ReqReady             one-cycle one-hot accept pulse
//   UartPalDataIn/En     byte and enable to the Uart
//   UartPalDataInPermit  Uart idle indication
//   GrantId              index of the current/most recent owner
//   Busy                 FSM not idle
//   TxDone / TxErr       frame complete / permit timeout pulses
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int EN_HOLD        = UART_EN_HOLD,
    parameter int PERMIT_TIMEOUT = UART_PERMIT_TIMEOUT
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_REQ-1:0]         ReqValid,
    input  logic [NUM_REQ*8-1:0]       ReqData,
    output logic [NUM_REQ-1:0]         ReqReady,
    output logic [7:0]                 UartPalDataIn,
    output logic                       UartPalDataInEn,
    input  logic                       UartPalDataInPermit,
    output logic [$clog2(NUM_REQ)-1:0] GrantId,
    output logic                       Busy,
    output logic                       TxDone,
    output logic                       TxErr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int EN_W  = $clog2(EN_HOLD + 1);
    localparam int TMO_W = $clog2(PERMIT_TIMEOUT + 1);

    tx_arb_state_t        state, stateNext;
    logic [IDX_W-1:0]     lastGrant;
    logic [EN_W-1:0]      enCnt;
    logic [TMO_W-1:0]     tmoCnt;

    logic [NUM_REQ-1:0]   pickOneHot;
    logic [IDX_W-1:0]     pickIdx;
    logic                 pickValid;

    logic                 enHoldDone;
    logic                 tmoHit;

    logic [NUM_REQ-1:0]   readyNext;
    logic                 enNext;
    logic                 doneNext;
    logic                 errNext;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uPicker (
        .reqVec      (ReqValid),
        .lastGrant   (lastGrant),
        .grantOneHot (pickOneHot),
        .grantIdx    (pickIdx),
        .grantValid  (pickValid)
    );

    assign enHoldDone = (enCnt == EN_W'(EN_HOLD - 1));
    assign tmoHit     = (tmoCnt == TMO_W'(PERMIT_TIMEOUT - 1));
    assign Busy       = (state != ST_IDLE);

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) state <= ST_IDLE;
        else     state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:      if (|ReqValid && UartPalDataInPermit) stateNext = ST_ARB;
            // Requests are re-sampled here; a fully withdrawn request aborts.
            ST_ARB:       stateNext = pickValid ? ST_DRIVE : ST_IDLE;
            ST_DRIVE:     if (enHoldDone) stateNext = ST_WAIT_LOW;
            // A low Permit wins over a coincident timeout.
            ST_WAIT_LOW:  if (!UartPalDataInPermit) stateNext = ST_WAIT_HIGH;
                          else if (tmoHit)          stateNext = ST_IDLE;
            ST_WAIT_HIGH: if (UartPalDataInPermit)  stateNext = ST_IDLE;
            default:      stateNext = ST_IDLE;
        endcase
    end

    // Output decode; every handshake/Uart output is registered, so each
    // appears one cycle after the state that produces it.
    always_comb begin
        readyNext = '0;
        enNext    = 1'b0;
        doneNext  = 1'b0;
        errNext   = 1'b0;
        case (state)
            ST_ARB:       readyNext = pickOneHot;
            ST_DRIVE:     enNext    = 1'b1;
            ST_WAIT_LOW:  errNext   = UartPalDataInPermit && tmoHit;
            ST_WAIT_HIGH: doneNext  = UartPalDataInPermit;
            default:      ;
        endcase
    end

    // Registered outputs, data capture and counters
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ReqReady        <= '0;
            UartPalDataIn   <= '0;
            UartPalDataInEn <= 1'b0;
            GrantId         <= '0;
            TxDone          <= 1'b0;
            TxErr           <= 1'b0;
            lastGrant       <= IDX_W'(NUM_REQ - 1);
            enCnt           <= '0;
            tmoCnt          <= '0;
        end else begin
            ReqReady        <= readyNext;
            UartPalDataInEn <= enNext;
            TxDone          <= doneNext;
            TxErr           <= errNext;

            if (state == ST_ARB && pickValid) begin
                UartPalDataIn <= ReqData[8*pickIdx +: 8];
                GrantId       <= pickIdx;
                lastGrant     <= pickIdx;
            end

            // Counters run only in their own state and saturate at the top.
            if (state == ST_DRIVE) begin
                if (enCnt != EN_W'(EN_HOLD)) enCnt <= enCnt + 1'b1;
            end else begin
                enCnt <= '0;
            end

            if (state == ST_WAIT_LOW) begin
                if (tmoCnt != TMO_W'(PERMIT_TIMEOUT)) tmoCnt <= tmoCnt + 1'b1;
            end else begin
                tmoCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Cycle-stepped bench: requesters hold byte queues and present the next byte
// after each accept pulse; a simple Uart model drops and re-raises Permit
// after each enable window. Expected grant order comes from a queue-level
// round-robin model or from hand-written tables.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int EN_HOLD        = 48;
    localparam int PERMIT_TIMEOUT = 1024;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  ReqValid;
    logic [31:0] ReqData;
    logic [3:0]  ReqReady;
    logic [7:0]  UartPalDataIn;
    logic        UartPalDataInEn;
    logic        UartPalDataInPermit;
    logic [1:0]  GrantId;
    logic        Busy, TxDone, TxErr;

    always #5 Clk = ~Clk;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .EN_HOLD        (EN_HOLD),
        .PERMIT_TIMEOUT (PERMIT_TIMEOUT)
    ) dut (
        .Clk                 (Clk),
        .Rst                 (Rst),
        .ReqValid            (ReqValid),
        .ReqData             (ReqData),
        .ReqReady            (ReqReady),
        .UartPalDataIn       (UartPalDataIn),
        .UartPalDataInEn     (UartPalDataInEn),
        .UartPalDataInPermit (UartPalDataInPermit),
        .GrantId             (GrantId),
        .Busy                (Busy),
        .TxDone              (TxDone),
        .TxErr               (TxErr)
    );

    int nCmp = 0, nErr = 0, cyc = 0;

    logic [7:0] rqData [NUM_REQ][16];
    int         rqLen  [NUM_REQ];
    int         rqPos  [NUM_REQ];

    bit autoReq = 1'b1, autoUart = 1'b0, checkEnLen = 1'b1;
    int uPhase = 0, uCnt = 0, lowDly = 2, highDly = 10;
    logic prevEn = 1'b0;
    int enRun = 0;

    int         txIdLog   [64];
    logic [7:0] txByteLog [64];
    int txCount = 0, doneCount = 0, errCount = 0, readyCount = 0;
    int firstReadyCyc = -1, firstEnCyc = -1;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;      // byte for requester i at [8i+7:8i]
        int          expN;
        logic [7:0]  expIds;    // k-th grant at [2k+1:2k]
        logic [31:0] expBytes;  // k-th byte at [8k+7:8k]
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyReq();
        if (autoReq) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rqPos[i] < rqLen[i]) begin
                    ReqValid[i]      = 1'b1;
                    ReqData[8*i +: 8] = rqData[i][rqPos[i]];
                end else begin
                    ReqValid[i]      = 1'b0;
                    ReqData[8*i +: 8] = 8'h00;
                end
            end
        end
    endtask

    task automatic loadReq(input int i, input logic [7:0] b);
        rqData[i][rqLen[i]] = b;
        rqLen[i]++;
    endtask

    task automatic clearReqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            rqLen[i] = 0;
            rqPos[i] = 0;
        end
    endtask

    task automatic clearLogs();
        txCount = 0; doneCount = 0; errCount = 0; readyCount = 0;
        firstReadyCyc = -1; firstEnCyc = -1;
    endtask

    // One clock: sample registered outputs 1 time unit after the edge,
    // update the logs, the Uart model and the requesters.
    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        if (ReqReady != 4'b0000) begin
            chk("ready_onehot", 32'($onehot(ReqReady)), 32'd1);
            readyCount++;
            if (firstReadyCyc < 0) firstReadyCyc = cyc;
            for (int i = 0; i < NUM_REQ; i++)
                if (ReqReady[i]) rqPos[i]++;
        end
        if (UartPalDataInEn && !prevEn) begin
            if (txCount < 64) begin
                txIdLog[txCount]   = int'(GrantId);
                txByteLog[txCount] = UartPalDataIn;
            end
            txCount++;
            if (firstEnCyc < 0) firstEnCyc = cyc;
        end
        if (UartPalDataInEn) enRun++;
        if (!UartPalDataInEn && prevEn) begin
            if (checkEnLen) chk("en_hold", 32'(enRun), 32'(EN_HOLD));
            enRun = 0;
        end
        if (TxDone) doneCount++;
        if (TxErr)  errCount++;
        if (autoUart) begin
            if (prevEn && !UartPalDataInEn) begin
                uPhase = 1; uCnt = lowDly;
            end else if (uPhase == 1) begin
                if (uCnt == 0) begin UartPalDataInPermit = 1'b0; uPhase = 2; uCnt = highDly; end
                else uCnt--;
            end else if (uPhase == 2) begin
                if (uCnt == 0) begin UartPalDataInPermit = 1'b1; uPhase = 0; end
                else uCnt--;
            end
        end
        prevEn = UartPalDataInEn;
        applyReq();
    endtask

    task automatic doReset();
        Rst = 1'b1;
        clearReqs();
        autoReq = 1'b1;
        ReqValid = '0; ReqData = '0;
        UartPalDataInPermit = 1'b1;
        uPhase = 0; autoUart = 1'b0; checkEnLen = 1'b1;
        step(); step();
        Rst = 1'b0;
        enRun = 0;
        clearLogs();
    endtask

    task automatic waitDone(input int target, input int budget);
        int n;
        n = 0;
        while (doneCount < target && n < budget) begin
            step();
            n++;
        end
        chk("done_count", 32'(doneCount), 32'(target));
    endtask

    vec_t vecs [4];
    int   expId [$];
    logic [7:0] expByte [$];
    int   rem [NUM_REQ];
    int   mLast, total, s, n, k;
    bit   found;

    initial begin
        vecs[0] = '{mask: 4'b0010, data: 32'h0000_c100, expN: 1, expIds: 8'b00_00_00_01, expBytes: 32'h0000_00c1};
        vecs[1] = '{mask: 4'b1111, data: 32'h1312_1110, expN: 4, expIds: 8'b11_10_01_00, expBytes: 32'h1312_1110};
        vecs[2] = '{mask: 4'b1010, data: 32'hb300_5a00, expN: 2, expIds: 8'b00_00_11_01, expBytes: 32'h0000_b35a};
        vecs[3] = '{mask: 4'b0101, data: 32'h007e_0081, expN: 2, expIds: 8'b00_00_10_00, expBytes: 32'h0000_7e81};

        // Reset state
        doReset();
        chk("rst_ready",  32'(ReqReady), 32'd0);
        chk("rst_en",     32'(UartPalDataInEn), 32'd0);
        chk("rst_data",   32'(UartPalDataIn), 32'd0);
        chk("rst_grant",  32'(GrantId), 32'd0);
        chk("rst_busy",   32'(Busy), 32'd0);
        chk("rst_done",   32'(TxDone), 32'd0);
        chk("rst_err",    32'(TxErr), 32'd0);

        // Table: each vector starts from reset, so the search starts at 0.
        for (int v = 0; v < 4; v++) begin
            doReset();
            for (int i = 0; i < NUM_REQ; i++)
                if (vecs[v].mask[i]) loadReq(i, vecs[v].data[8*i +: 8]);
            applyReq();
            autoUart = 1'b1; lowDly = 2; highDly = 10;
            s = cyc;
            waitDone(vecs[v].expN, 200 * vecs[v].expN);
            chk("vec_ready_lat", 32'(firstReadyCyc - s), 32'd2);
            chk("vec_en_lat",    32'(firstEnCyc - s), 32'd3);
            chk("vec_tx_count",  32'(txCount), 32'(vecs[v].expN));
            for (int t = 0; t < vecs[v].expN && t < txCount; t++) begin
                chk("vec_grant_id", 32'(txIdLog[t]), 32'(vecs[v].expIds[2*t +: 2]));
                chk("vec_byte",     32'(txByteLog[t]), 32'(vecs[v].expBytes[8*t +: 8]));
            end
            chk("vec_err", 32'(errCount), 32'd0);
            if (v == 0) chk("single_grantid_hold", 32'(GrantId), 32'd1);
        end

        // Permit low in IDLE blocks arbitration
        doReset();
        UartPalDataInPermit = 1'b0;
        loadReq(2, 8'h42);
        applyReq();
        repeat (10) step();
        chk("busy_no_ready", 32'(readyCount), 32'd0);
        chk("busy_idle",     32'(Busy), 32'd0);
        UartPalDataInPermit = 1'b1;
        s = cyc; n = 0;
        while (ReqReady == 4'b0000 && n < 10) begin step(); n++; end
        chk("busy_grant_lat", 32'(cyc - s), 32'd2);
        chk("busy_ready_vec", 32'(ReqReady), 32'b0100);
        autoUart = 1'b1;
        waitDone(1, 200);
        chk("busy_byte", 32'(txByteLog[0]), 32'h42);

        // Permit never falls: timeout counted from WAIT_LOW entry, which is
        // the end of ARB (ReqReady cycle) plus EN_HOLD drive cycles.
        doReset();
        loadReq(0, 8'h66);
        applyReq();
        s = cyc; n = 0;
        while (!TxErr && n < 2000) begin step(); n++; end
        chk("tmo_latency", 32'(cyc - s), 32'(2 + EN_HOLD + PERMIT_TIMEOUT));
        step();
        chk("tmo_pulse_len", 32'(TxErr), 32'd0);
        chk("tmo_busy",      32'(Busy), 32'd0);
        chk("tmo_no_done",   32'(doneCount), 32'd0);
        chk("tmo_err_count", 32'(errCount), 32'd1);

        // Reset during DRIVE
        doReset();
        checkEnLen = 1'b0;
        loadReq(0, 8'ha3);
        applyReq();
        repeat (13) step();
        chk("mid_en_high", 32'(UartPalDataInEn), 32'd1);
        chk("mid_byte",    32'(UartPalDataIn), 32'ha3);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("mid_en_drop", 32'(UartPalDataInEn), 32'd0);
        chk("mid_busy",    32'(Busy), 32'd0);
        checkEnLen = 1'b1;
        loadReq(0, 8'h11);
        loadReq(1, 8'h22);
        applyReq();
        autoUart = 1'b1;
        waitDone(2, 400);
        chk("mid_first_after_rst", 32'(txIdLog[1]), 32'd0);
        chk("mid_first_byte",      32'(txByteLog[1]), 32'h11);
        chk("mid_second_after_rst", 32'(txIdLog[2]), 32'd1);

        // Request withdrawn during ARB
        doReset();
        autoReq = 1'b0;
        ReqValid = 4'b0001; ReqData = 32'h0000_0055;
        step();
        ReqValid = 4'b0000;
        repeat (61) step();
        chk("wd_no_ready", 32'(readyCount), 32'd0);
        chk("wd_no_en",    32'(txCount), 32'd0);
        chk("wd_busy",     32'(Busy), 32'd0);
        autoReq = 1'b1;

        // Random rounds vs queue-level round-robin model
        doReset();
        mLast = NUM_REQ - 1;
        for (int r = 0; r < 3; r++) begin
            clearLogs();
            clearReqs();
            total = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                n = int'($urandom_range(0, 3));
                for (int j = 0; j < n; j++) loadReq(i, 8'($urandom));
                total += n;
            end
            if (total == 0) begin loadReq(0, 8'($urandom)); total = 1; end
            expId.delete(); expByte.delete();
            for (int i = 0; i < NUM_REQ; i++) rem[i] = rqLen[i];
            for (int t = 0; t < total; t++) begin
                found = 1'b0;
                for (int j = 1; j <= NUM_REQ; j++) begin
                    k = (mLast + j) % NUM_REQ;
                    if (!found && rem[k] > 0) begin
                        found = 1'b1;
                        expId.push_back(k);
                        expByte.push_back(rqData[k][rqLen[k] - rem[k]]);
                        rem[k]--;
                        mLast = k;
                    end
                end
            end
            lowDly  = int'($urandom_range(0, 4));
            highDly = int'($urandom_range(1, 12));
            autoUart = 1'b1;
            applyReq();
            waitDone(total, 150 * total);
            chk("rnd_tx_count", 32'(txCount), 32'(total));
            for (int t = 0; t < total && t < txCount; t++) begin
                chk("rnd_grant_id", 32'(txIdLog[t]), 32'(expId[t]));
                chk("rnd_byte",     32'(txByteLog[t]), 32'(expByte[t]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single parallel transmit port of the `Uart` block among `NUM_REQ` independent byte requesters. It accepts one byte at a time from a requester over a valid/ready handshake, drives `PalDataIn`/`PalDataInEn` with the required enable hold time, and tracks `PalDataInPermit` to learn when the serial frame is finished. It sits between the system-side producers and the `Uart` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `EN_HOLD`, 48: cycles `UartPalDataInEn` stays high per byte. This is one bit period at the 82 ns clock and 256000 baud.
- `PERMIT_TIMEOUT`, 1024: maximum cycles to wait for `UartPalDataInPermit` to fall after the enable window closes.
- `Clk`  in  1  system clock; all logic is on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `ReqValid`  in  NUM_REQ  per-requester byte available.
- `ReqData`  in  NUM_REQ*8  packed bytes; requester i occupies bits [8i+7:8i].
- `ReqReady`  out  NUM_REQ  one-cycle accept pulse, one-hot.
- `UartPalDataIn`  out  8  byte to `Uart` `PalDataIn`.
- `UartPalDataInEn`  out  1  to `Uart` `PalDataInEn`.
- `UartPalDataInPermit`  in  1  from `Uart`; high means the transmitter is idle.
- `GrantId`  out  $clog2(NUM_REQ)  index of the requester currently owning the port.
- `Busy`  out  1  high whenever the FSM is not in IDLE.
- `TxDone`  out  1  one-cycle pulse when a frame completes.
- `TxErr`  out  1  one-cycle pulse on a permit timeout.

## Operation
- **FSM states:** IDLE, ARB, DRIVE, WAIT_LOW, WAIT_HIGH.
- **IDLE:**
  - Go to ARB when any `ReqValid` bit is set and `UartPalDataInPermit` is 1.
  - A request that arrives while Permit is 0 waits; nothing is granted.
- **ARB (one cycle):**
  - Pick the first valid requester, searching from `LastGrant+1` modulo `NUM_REQ`.
  - Pulse its `ReqReady` bit. Latch its byte into the data register and its index into `GrantId` and `LastGrant`.
  - Go to DRIVE.
  - If every `ReqValid` bit dropped during this cycle, return to IDLE with no pulse.
- **DRIVE:**
  - `UartPalDataInEn`=1 and `UartPalDataIn` = latched byte for exactly `EN_HOLD` cycles.
  - Then deassert the enable and go to WAIT_LOW.
- **WAIT_LOW:**
  - Wait for Permit=0. This also passes if Permit already fell during DRIVE; it is sampled from the first WAIT_LOW cycle.
  - When seen, go to WAIT_HIGH.
  - On timeout, pulse `TxErr` and go to IDLE.
- **WAIT_HIGH:** wait for Permit=1, then pulse `TxDone` and go to IDLE. There is no timeout in this state.
- **Timeout counter:**
  - Cleared on entry to WAIT_LOW.
  - `TxErr` fires when it reaches `PERMIT_TIMEOUT`-1 with Permit still 1.
- **Requester protocol:** a requester holds `ReqValid` and `ReqData` stable until it sees its `ReqReady` pulse.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,2,3,0,…
- **Byte capture:** a requester dropping `ReqValid` after acceptance has no effect; the byte is already latched.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - `LastGrant` = NUM_REQ-1, so requester 0 wins first.
  - All outputs 0; `GrantId` = 0.
- **Latency to enable:** from `ReqValid` rising in IDLE (with Permit=1), `ReqReady` pulses 2 cycles later and `UartPalDataInEn` rises in the same cycle as `ReqReady`+1.
- **Back-to-back frames:** after `TxDone` the next ARB occurs at least 2 cycles later. No gap is imposed beyond that.
- **`GrantId` validity:** valid from the ARB cycle until the next ARB; it holds its value in IDLE.
- **`Rst` mid-transfer:**
  - Enable drops the next cycle and the FSM returns to IDLE.
  - The latched byte is discarded, and the `Uart` may finish its current frame on its own.
- **Priority rule:** a `ReqValid` change in the same cycle as ARB is sampled in that cycle.
- **Counter widths:**
  - The EN counter is `$clog2(EN_HOLD+1)` bits.
  - The timeout counter is `$clog2(PERMIT_TIMEOUT+1)` bits.
  - Both saturate and never wrap.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum `tx_arb_state_t`.
  - Default constants `UART_EN_HOLD` and `UART_PERMIT_TIMEOUT`.
- **Sub-module `rr_arbiter`:** combinational round-robin picker, taking the request vector and last grant and returning a one-hot grant plus an index. It is reusable for a future RX distributor.
- **Top-level contents:** the FSM, counters, data register and outputs are in `uart_tx_arbiter`.

## Test plan
- **Single request:** req1 valid with 8'hc1, Permit=1.
  - `ReqReady`=4'b0010, then En high for 48 cycles with `UartPalDataIn`=8'hc1.
  - Drive Permit low, then high 10 cycles later; `TxDone` pulses once and `GrantId`=1.
- **All four valid (data 8'h10..8'h13):** grant order is 0,1,2,3, and 4 `TxDone` pulses occur in that order.
- **Busy at request time:** Permit held at 0 in IDLE while req2 is valid.
  - No `ReqReady` while Permit=0.
  - Raise Permit; the grant follows 2 cycles later.
- **Permit never falls:** Permit stuck at 1 after DRIVE.
  - `TxErr` pulses exactly `PERMIT_TIMEOUT` cycles after WAIT_LOW entry.
  - FSM returns to IDLE; `TxDone` never fires.
- **Reset mid-transfer:** `Rst` for 1 cycle during DRIVE (byte 8'ha3).
  - En goes to 0 the next cycle, `Busy`=0.
  - After reset, requester 0 is granted first.
- **Withdrawn request:** req0 drops `ReqValid` in the ARB cycle with no other requests.
  - No `ReqReady`; FSM returns to IDLE and En is never asserted.
